// File: rtl/fetch_unit_l2_pkg.sv
// Shared widths and PC arithmetic for the fetch unit.
// Contents: address/instruction widths, PC step, next_pc() helper.
package fetch_unit_l2_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_unit_l2_fetch_buffer.sv
// Parameterized synchronous FIFO with push/pop/flush and occupancy count.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push_i        write push_data_i at tail (dropped if full and not popping)
//   push_data_i   entry to enqueue
//   pop_i         remove head (ignored when empty)
//   flush_i       empty the FIFO; overrides push/pop in the same cycle
//   head_o        current head entry (stale when empty)
//   count_o       number of valid entries
module fetch_unit_l2_fetch_buffer #(
    parameter int unsigned p_width = 64,
    parameter int unsigned p_depth = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [p_width-1:0]             push_data_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    output logic [p_width-1:0]             head_o,
    output logic [$clog2(p_depth+1)-1:0]   count_o
);

    localparam int unsigned CNT_W = $clog2(p_depth + 1);
    localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;

    logic [p_width-1:0] mem_q [p_depth];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    // Pointer advance with wrap for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(p_depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != CNT_W'(p_depth)) || do_pop);

    // Next-state for pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit_l2.sv
// In-order single-fetch front end with squash support.
// Issues PC-sequential requests to instruction memory, buffers responses,
// tags each instruction with a sequence number and hands it to decode.
// A squash redirects the PC, flushes buffered instructions and marks
// in-flight responses as wrong-path so they are discarded on return.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mem_req_val/rdy/addr        request channel to instruction memory
//   mem_resp_val/rdy/data       in-order response channel (rdy tied high)
//   d_val/rdy/inst/pc/seq_num   F->D handshake towards decode
//   squash_val/target/seq_num   redirect notification from decode/issue
module fetch_unit_l2
    import fetch_unit_l2_pkg::*;
#(
    parameter logic [ADDR_W-1:0] p_rst_addr      = 32'h200,
    parameter int unsigned       p_seq_num_bits  = 5,
    parameter int unsigned       p_max_in_flight = 2
) (
    input  logic                      clk,
    input  logic                      rst,

    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [ADDR_W-1:0]         mem_req_addr,

    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy,
    input  logic [INST_W-1:0]         mem_resp_data,

    output logic                      d_val,
    input  logic                      d_rdy,
    output logic [INST_W-1:0]         d_inst,
    output logic [ADDR_W-1:0]         d_pc,
    output logic [p_seq_num_bits-1:0] d_seq_num,

    input  logic                      squash_val,
    input  logic [ADDR_W-1:0]         squash_target,
    input  logic [p_seq_num_bits-1:0] squash_seq_num
);

    localparam int unsigned CNT_W = $clog2(p_max_in_flight + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned SEQ_W = p_seq_num_bits;
    localparam int unsigned ENT_W = INST_W + ADDR_W;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  buf_count;
    logic [ADDR_W-1:0] resp_pc;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    logic req_xfer, resp_xfer, resp_keep, d_xfer;

    // Request side: issue only while in-flight plus buffered stays below the cap.
    assign mem_req_val  = !rst && !squash_val &&
                          ((SUM_W'(outstanding) + SUM_W'(buf_count)) < SUM_W'(p_max_in_flight));
    assign mem_req_addr = pc_q;
    assign req_xfer     = mem_req_val && mem_req_rdy;

    // Response side: squash-cycle and wrong-path responses are never buffered.
    assign mem_resp_rdy = 1'b1;
    assign resp_xfer    = mem_resp_val;
    assign resp_keep    = resp_xfer && !squash_val && (drop_q == '0);

    assign push_entry.inst = mem_resp_data;
    assign push_entry.pc   = resp_pc;

    // Deliver side.
    assign d_val     = !rst && !squash_val && (buf_count != '0);
    assign d_inst    = head_entry.inst;
    assign d_pc      = head_entry.pc;
    assign d_seq_num = seq_q;
    assign d_xfer    = d_val && d_rdy;

    // PC of every accepted request, popped by its response (kept or dropped);
    // its occupancy is therefore the outstanding-request count.
    fetch_unit_l2_fetch_buffer #(
        .p_width (ADDR_W),
        .p_depth (p_max_in_flight)
    ) u_pc_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_xfer),
        .push_data_i (pc_q),
        .pop_i       (resp_xfer),
        .flush_i     (1'b0),
        .head_o      (resp_pc),
        .count_o     (outstanding)
    );

    // Right-path instructions awaiting decode; flushed on squash.
    fetch_unit_l2_fetch_buffer #(
        .p_width (ENT_W),
        .p_depth (p_max_in_flight)
    ) u_inst_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (resp_keep),
        .push_data_i (push_entry),
        .pop_i       (d_xfer),
        .flush_i     (squash_val),
        .head_o      (head_entry),
        .count_o     (buf_count)
    );

    // Next-state for PC, sequence number and wrong-path drop count.
    always_comb begin
        pc_d   = pc_q;
        seq_d  = seq_q;
        drop_d = drop_q;
        if (squash_val) begin
            pc_d   = squash_target;
            seq_d  = squash_seq_num + SEQ_W'(1);
            // Everything still in flight after this cycle's response is wrong-path.
            drop_d = outstanding - CNT_W'(resp_xfer);
        end else begin
            if (req_xfer) begin
                pc_d = next_pc(pc_q);
            end
            if (d_xfer) begin
                seq_d = seq_q + SEQ_W'(1);
            end
            if (resp_xfer && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= p_rst_addr;
            seq_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            seq_q  <= seq_d;
            drop_q <= drop_d;
        end
    end

endmodule
